imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Unpacks a byte stream into 12-bit instructions and writes them to instruction memory.
// Latency: one write strobe the cycle after each completing byte; cpu_resetN rises the cycle after the good checksum.
// Backpressure: in_ready is high in every loading state (one byte per cycle) and low only in RUN.
//
// Ports:
//   clk, resetN                     clock and asynchronous active-low reset
//   in_valid, in_data, in_ready     byte stream handshake; a transfer is in_valid & in_ready
//   load_req                        single-cycle pulse; starts a reload, honoured only in RUN
//   imem_we, imem_addr, imem_wdata  instruction-memory write port
//   cpu_resetN                      active-low processor reset, released after a verified load
//   busy, error                     busy = not in RUN; error = sticky checksum failure
module imem_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   load_req,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_resetN,
  output logic                   busy,
  output logic                   error
);

  // One extra bit so a full-depth count (header 0) is representable.
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    CSUM = 3'd4,
    RUN  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             acc_q, acc_d;
  logic [7:0]             b0_q, b0_d;
  logic [3:0]             nib_q, nib_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   cpu_resetN_q, cpu_resetN_d;
  logic                   error_q, error_d;

  logic                   xfer;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   last;

  assign xfer    = in_valid & in_ready_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  // True when the write being issued now is the N-th one.
  assign last    = (cnt_inc == n_q);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    b0_d         = b0_q;
    nib_d        = nib_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_resetN_d = cpu_resetN_q;
    error_d      = error_q;

    case (state_q)
      HDR: begin
        if (xfer) begin
          // A zero header encodes a full-depth load.
          n_d     = (in_data == 8'd0) ? (CNT_W'(1) << ADDR_WIDTH) : CNT_W'(in_data);
          cnt_d   = '0;
          acc_d   = 8'd0;
          state_d = P0;
        end
      end
      P0: begin
        if (xfer) begin
          b0_d    = in_data;
          acc_d   = acc_q + in_data;
          state_d = P1;
        end
      end
      P1: begin
        if (xfer) begin
          // For an odd final instruction the low nibble here is padding; it is
          // captured but never used because the load goes straight to CSUM.
          acc_d   = acc_q + in_data;
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = {b0_q, in_data[7:4]};
          nib_d   = in_data[3:0];
          cnt_d   = cnt_inc;
          state_d = last ? CSUM : P2;
        end
      end
      P2: begin
        if (xfer) begin
          acc_d   = acc_q + in_data;
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = {nib_q, in_data};
          cnt_d   = cnt_inc;
          state_d = last ? CSUM : P0;
        end
      end
      CSUM: begin
        if (xfer) begin
          if (in_data == acc_q) begin
            cpu_resetN_d = 1'b1;
            error_d      = 1'b0;
            state_d      = RUN;
          end else begin
            error_d = 1'b1;
            state_d = HDR;
          end
        end
      end
      RUN: begin
        if (load_req) begin
          cpu_resetN_d = 1'b0;
          error_d      = 1'b0;
          state_d      = HDR;
        end
      end
      default: state_d = HDR;
    endcase

    // Registered so they reflect the state being entered.
    in_ready_d = (state_d != RUN);
    busy_d     = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= HDR;
      n_q          <= '0;
      cnt_q        <= '0;
      acc_q        <= 8'd0;
      b0_q         <= 8'd0;
      nib_q        <= 4'd0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_resetN_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      b0_q         <= b0_d;
      nib_q        <= nib_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_resetN_q <= cpu_resetN_d;
      error_q      <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_resetN = cpu_resetN_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams and checks writes, handshake and status.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        resetN;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        load_req;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [11:0] imem_wdata;
  logic        cpu_resetN;
  logic        busy;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  wa[$];
  logic [11:0] wd[$];

  imem_loader #(.ADDR_WIDTH(8), .INSTR_WIDTH(12)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_resetN (cpu_resetN),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write capture, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_before_xfer", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic chk_writes_a(input string tag);
    chk({tag, "_nwr"}, wa.size(), 2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 8'h00);
      chk({tag, "_d0"}, wd[0], 12'h0A5);
      chk({tag, "_a1"}, wa[1], 8'h01);
      chk({tag, "_d1"}, wd[1], 12'h3C1);
    end
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_cpu"}, cpu_resetN, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_err"}, error, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_cpu"}, cpu_resetN, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_err"}, error, 0);
  endtask

  logic [11:0] instr[256];
  logic [7:0]  sum;
  logic [7:0]  pb;

  initial begin
    resetN   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    load_req = 1'b0;
    idle(3);
    chk_reset_vals("rst");
    resetN = 1'b1;
    idle(2);

    // Two-instruction load.
    wa.delete(); wd.delete();
    send(8'h02); send(8'h0A); send(8'h53); send(8'hC1);
    chk("a_cpu_pre", cpu_resetN, 0);
    chk("a_busy_pre", busy, 1);
    send(8'h1E);
    chk_run("a");
    idle(2);
    chk_writes_a("a");

    // load_req in RUN.
    pulse_load_req();
    chk("lr_cpu", cpu_resetN, 0);
    chk("lr_rdy", in_ready, 1);
    chk("lr_busy", busy, 1);

    // Odd count.
    wa.delete(); wd.delete();
    send(8'h01); send(8'h7F); send(8'hF0); send(8'h6F);
    chk_run("odd");
    idle(2);
    chk("odd_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("odd_a0", wa[0], 8'h00);
      chk("odd_d0", wd[0], 12'h7FF);
    end

    // Bad checksum, then a good stream.
    pulse_load_req();
    wa.delete(); wd.delete();
    send(8'h02); send(8'h0A); send(8'h53); send(8'hC1); send(8'h1F);
    chk("bad_err", error, 1);
    chk("bad_cpu", cpu_resetN, 0);
    chk("bad_busy", busy, 1);
    chk("bad_rdy", in_ready, 1);
    idle(2);
    chk_writes_a("bad");
    wa.delete(); wd.delete();
    send(8'h02);
    chk("sticky_err", error, 1);
    send(8'h0A); send(8'h53); send(8'hC1); send(8'h1E);
    chk_run("recov");
    idle(2);
    chk_writes_a("recov");

    // Full depth.
    pulse_load_req();
    wa.delete(); wd.delete();
    for (int i = 0; i < 256; i++) instr[i] = 12'((i * 291 + 7) & 12'hFFF);
    sum = 8'h00;
    send(8'h00);
    for (int i = 0; i < 256; i += 2) begin
      pb = instr[i][11:4];                     send(pb); sum = sum + pb;
      pb = {instr[i][3:0], instr[i+1][11:8]};  send(pb); sum = sum + pb;
      pb = instr[i+1][7:0];                    send(pb); sum = sum + pb;
    end
    chk("full_cpu_pre", cpu_resetN, 0);
    send(sum);
    chk_run("full");
    idle(2);
    chk("full_nwr", wa.size(), 256);
    if (wa.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        chk("full_addr", wa[i], i);
        chk("full_data", wd[i], instr[i]);
      end
    end

    // Gaps between bytes, with a load_req outside RUN that must be ignored.
    pulse_load_req();
    wa.delete(); wd.delete();
    send(8'h02); idle(3);
    send(8'h0A); idle(1); pulse_load_req(); idle(1);
    send(8'h53); idle(3);
    send(8'hC1); idle(3);
    chk("gap_cpu_pre", cpu_resetN, 0);
    send(8'h1E);
    chk_run("gap");
    idle(2);
    chk_writes_a("gap");

    // Reset mid-load.
    pulse_load_req();
    send(8'h02); send(8'h0A); send(8'h53);
    #1;
    resetN = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    idle(2);
    resetN = 1'b1;
    idle(1);
    wa.delete(); wd.delete();
    send(8'h02); send(8'h0A); send(8'h53); send(8'hC1); send(8'h1E);
    chk_run("post_rst");
    idle(2);
    chk_writes_a("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
